adc_scan_sequencer: RTL
=======================

// Module: adc_scan_sequencer
// PURPOSE
//  Sequences the shared SPI ADC master over up to N_CH channels. Each sample tick starts one scan frame:
//  builds the per-channel command, handshakes ENA/FIN with the master, tags each result with its channel,
//  writes it to the sample FIFO. Sits between SPI_MASTER_ADC and FIFO_IP; replaces free-running ENA toggling.
// PARAMETERS
//  N_CH        4     channels scanned (1..4)
//  CH_BITS     2     channel index width
//  PERIOD      256   SYS_CLK cycles between sample ticks (>=2)
//  FIN_TIMEOUT 1023  max SYS_CLK cycles in CONVERT before abort
// PORTS
//  SYS_CLK      in   1        system clock (CLK_FAST domain)
//  reset_n      in   1        asynchronous, active-low reset
//  run          in   1        enable; low = synchronous abort to IDLE
//  clr          in   1        synchronous restart: tick counter, frame, sticky flags
//  ch_mask      in   N_CH     bit i=1 -> channel i included in frame
//  adc_ena      out  1        to master ENA
//  adc_cmd      out  16       to master DATA_MOSI
//  adc_fin      in   1        from master FIN
//  adc_data     in   16       from master DATA_MISO
//  fifo_full    in   1        FIFO full flag
//  fifo_wrreq   out  1        one-cycle FIFO write strobe
//  fifo_data    out  16       {ch[1:0], adc_data[14:1]}
//  frame_done   out  1        one-cycle pulse after last enabled channel written
//  busy         out  1        high in any state except IDLE/WAIT_TICK/HALT
//  overflow     out  1        sticky: write attempted while fifo_full
//  overrun      out  1        sticky: tick arrived while frame in progress
//  timeout      out  1        sticky: FIN not seen within FIN_TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0; adc_cmd = command for ch 0; state IDLE; tick counter 0.
//  Command: adc_cmd = {4'b0001,1'b1,2'b00,ch[1:0],7'b1000000}; registered, stable whenever adc_ena=1.
//  Tick: counter 0..PERIOD-1 while run & ~clr, wraps; tick = (count==PERIOD-1). run=0 or clr -> count=0.
//  States: IDLE -> WAIT_TICK when run. WAIT_TICK -> LOAD on tick if ch_mask!=0 (ch_mask==0: ticks ignored,
//   no frame_done). LOAD: pick lowest enabled ch >= current, register adc_cmd; next cycle -> CONVERT.
//  CONVERT: adc_ena=1; on cycle adc_fin=1 with previous sample 0, capture adc_data, -> WRITE.
//  WRITE (1 cycle): if ~fifo_full: fifo_wrreq=1, fifo_data=tagged sample; else no write, overflow<=1, -> HALT.
//  RELEASE: adc_ena=0 until adc_fin=0 (min 1 cycle); then next enabled ch -> LOAD, or none -> frame_done=1,
//   ch index reset to 0, -> WAIT_TICK.
//  Latency: tick cycle -> adc_ena high 2 cycles later; FIN rising edge sampled -> fifo_wrreq next cycle.
//  Overrun: tick while busy -> overrun<=1, tick dropped, frame continues.
//  Timeout: CONVERT lasts FIN_TIMEOUT cycles -> timeout<=1, adc_ena low, abort frame, no write, -> WAIT_TICK.
//  HALT: adc_ena=0, no ticks acted on; exits only via run=0 (-> IDLE) or clr (-> WAIT_TICK if run).
//  run=0 any state: next cycle adc_ena=0, fifo_wrreq=0, -> IDLE, partial sample discarded, sticky flags cleared.
//  clr has priority over all events in the same cycle; clears flags, ch index, counter.
//  ch_mask sampled at each LOAD; change mid-frame affects only channels not yet loaded.
//  Simultaneous tick and frame_done: frame ends, tick starts new frame (no overrun).
//  Async reset mid-transaction: adc_ena drops immediately; master must tolerate ENA loss.
// STRUCTURE
//  Shared package adc_pkg: state enum, ADC_CMD_PREFIX (7'b0001100), ADC_CMD_SUFFIX (7'b1000000),
//   cmd builder function, FIFO tag layout constants.
//  Sub-module adc_tick_gen (PERIOD counter + tick) is natural; FSM, edge detect, flags stay in top.
// TESTING
//  N_CH=4, ch_mask=4'b1111, PERIOD=256, master model FIN after 40 cycles -> 4 writes/frame, tags 0,1,2,3,
//   cmds 16'h1840/18C0/1940/19C0, frame_done once per 256 cycles.
//  ch_mask=4'b0101 -> writes tagged 0 then 2 only; ch_mask=0 -> no adc_ena, no writes for 1000 cycles.
//  fifo_full forced high before 3rd write -> 2 writes, overflow=1, adc_ena stays 0; clr -> scanning resumes.
//  Master FIN latency 100 cycles, 4 channels, PERIOD=256 -> overrun=1, no extra frame started.
//  FIN never asserted -> timeout=1 after 1023 cycles in CONVERT, adc_ena=0, no fifo_wrreq.
//  run dropped mid-CONVERT -> adc_ena=0 next cycle, no write; assert reset_n low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC scan sequencer: FSM states,
// SPI command framing and the tagged FIFO word layout.
package adc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StLoad,
        StConvert,
        StWrite,
        StRelease,
        StHalt
    } seq_state_e;

    localparam logic [6:0] ADC_CMD_PREFIX = 7'b0001100;
    localparam logic [6:0] ADC_CMD_SUFFIX = 7'b1000000;

    // FIFO word: {channel tag, adc_data[SAMPLE_MSB:SAMPLE_LSB]}
    localparam int unsigned TAG_W      = 2;
    localparam int unsigned SAMPLE_MSB = 14;
    localparam int unsigned SAMPLE_LSB = 1;
    localparam int unsigned SAMPLE_W   = SAMPLE_MSB - SAMPLE_LSB + 1;

    function automatic logic [15:0] build_cmd(input logic [1:0] ch);
        return {ADC_CMD_PREFIX, ch, ADC_CMD_SUFFIX};
    endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Free-running sample tick: counts 0..PERIOD-1 while enabled and pulses on
// the last count; held at zero while disabled.
module adc_tick_gen #(
    parameter int unsigned PERIOD = 256
) (
    input  logic SYS_CLK,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(PERIOD - 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = '0;
        if (enable && (count_q != LastCnt)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign tick = enable && (count_q == LastCnt);

    always_ff @(posedge SYS_CLK or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans the enabled ADC channels once per sample tick through the shared SPI
// master, tags each result with its channel and writes it to the sample FIFO.
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CH_BITS     = 2,
    parameter int unsigned PERIOD      = 256,
    parameter int unsigned FIN_TIMEOUT = 1023
) (
    input  logic            SYS_CLK,
    input  logic            reset_n,
    input  logic            run,
    input  logic            clr,
    input  logic [N_CH-1:0] ch_mask,
    output logic            adc_ena,
    output logic [15:0]     adc_cmd,
    input  logic            adc_fin,
    input  logic [15:0]     adc_data,
    input  logic            fifo_full,
    output logic            fifo_wrreq,
    output logic [15:0]     fifo_data,
    output logic            frame_done,
    output logic            busy,
    output logic            overflow,
    output logic            overrun,
    output logic            timeout
);

    localparam int unsigned TmoW = $clog2(FIN_TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(FIN_TIMEOUT - 1);

    seq_state_e          state_q, state_d;
    logic [CH_BITS-1:0]  ch_q, ch_d;
    logic [15:0]         cmd_q, cmd_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic                fin_q;
    logic                overflow_q, overflow_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;

    logic                tick;
    logic                fin_rise;
    logic                pick_found, next_found;
    logic [CH_BITS-1:0]  pick_ch, next_ch;
    logic                unused_data;

    adc_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick_gen (
        .SYS_CLK (SYS_CLK),
        .reset_n (reset_n),
        .enable  (run & ~clr),
        .tick    (tick)
    );

    assign fin_rise    = adc_fin & ~fin_q;
    assign unused_data = ^{adc_data[15], adc_data[0]};

    // pick: lowest enabled channel >= current; next: lowest enabled channel > current
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        next_found = 1'b0;
        next_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i] && (i >= int'(ch_q))) begin
                pick_found = 1'b1;
                pick_ch    = CH_BITS'(i);
            end
            if (ch_mask[i] && (i > int'(ch_q))) begin
                next_found = 1'b1;
                next_ch    = CH_BITS'(i);
            end
        end
    end

    assign busy = (state_q == StLoad) || (state_q == StConvert) ||
                  (state_q == StWrite) || (state_q == StRelease);

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cmd_d      = cmd_q;
        sample_d   = sample_q;
        tmo_d      = tmo_q;
        overflow_d = overflow_q;
        overrun_d  = overrun_q;
        timeout_d  = timeout_q;
        fifo_wrreq = 1'b0;
        frame_done = 1'b0;

        if (!run) begin
            state_d    = StIdle;
            ch_d       = '0;
            tmo_d      = '0;
            overflow_d = 1'b0;
            overrun_d  = 1'b0;
            timeout_d  = 1'b0;
        end else if (clr) begin
            state_d    = StWaitTick;
            ch_d       = '0;
            tmo_d      = '0;
            overflow_d = 1'b0;
            overrun_d  = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StWaitTick;
                StWaitTick: begin
                    if (tick && (ch_mask != '0)) begin
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    if (pick_found) begin
                        ch_d    = pick_ch;
                        cmd_d   = build_cmd(2'(pick_ch));
                        tmo_d   = '0;
                        state_d = StConvert;
                    end else begin
                        // mask shrank after the previous channel: nothing left to scan
                        frame_done = 1'b1;
                        ch_d       = '0;
                        state_d    = StWaitTick;
                    end
                end
                StConvert: begin
                    if (fin_rise) begin
                        sample_d = adc_data[SAMPLE_MSB:SAMPLE_LSB];
                        state_d  = StWrite;
                    end else if (tmo_q == TmoLast) begin
                        timeout_d = 1'b1;
                        ch_d      = '0;
                        state_d   = StWaitTick;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                StWrite: begin
                    if (!fifo_full) begin
                        fifo_wrreq = 1'b1;
                        state_d    = StRelease;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = StHalt;
                    end
                end
                StRelease: begin
                    if (!adc_fin) begin
                        if (next_found) begin
                            ch_d    = next_ch;
                            state_d = StLoad;
                        end else begin
                            frame_done = 1'b1;
                            ch_d       = '0;
                            state_d    = StWaitTick;
                        end
                    end
                end
                StHalt: state_d = StHalt;
                default: state_d = StIdle;
            endcase

            // A tick landing on the frame's last cycle starts the next frame at once
            if (tick && busy) begin
                if (frame_done) begin
                    if (ch_mask != '0) begin
                        state_d = StLoad;
                    end
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge SYS_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            cmd_q      <= build_cmd(2'b00);
            sample_q   <= '0;
            tmo_q      <= '0;
            fin_q      <= 1'b0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cmd_q      <= cmd_d;
            sample_q   <= sample_d;
            tmo_q      <= tmo_d;
            fin_q      <= adc_fin;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign adc_ena   = (state_q == StConvert);
    assign adc_cmd   = cmd_q;
    assign fifo_data = {2'(ch_q), sample_q};
    assign overflow  = overflow_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

endmodule
